// File: rtl/mem_data_pkg.sv
// Shared encodings and the access-legality rule for the memory data register.
package mem_data_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // off is zero-extended to 3 bits by the caller, so one function serves both widths.
  function automatic logic f_is_legal(input logic [1:0] size, input logic [2:0] off,
                                      input int data_w);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (off[0] == 1'b0);
      SZ_WORD: ok = (off[1:0] == 2'b00);
      default: ok = (data_w == 64) && (off == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mdr_extract.sv
// Combinational field extraction: shift the addressed bytes down, mask to the
// access size, then sign- or zero-extend to the full data width.
module mdr_extract
  import mem_data_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                   size,
  input  logic                         sign_ext,
  input  logic [$clog2(DATA_W/8)-1:0]  addr_off,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [DATA_W-1:0]            ext_data
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [6:0]        nbits;
  logic              sign_bit;

  always_comb begin
    shifted  = mem_rdata >> {addr_off, 3'b000};
    nbits    = 7'd8 << size;
    // When nbits equals DATA_W the shift overflows to zero and the mask becomes all ones.
    mask     = (DATA_W'(1) << nbits) - DATA_W'(1);
    sign_bit = |(shifted & (mask ^ (mask >> 1)));
    ext_data = (shifted & mask) | ((sign_ext && sign_bit) ? ~mask : '0);
  end

endmodule

// File: rtl/mem_data_reg_ctl.sv
// Memory data register with a single read handshake per load, bounded wait,
// and size/offset extraction into mdr_q. LEGACY=1 restores the free-running MDR.
module mem_data_reg_ctl
  import mem_data_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int LEGACY  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_req,
  input  logic [1:0]                   size,
  input  logic                         sign_ext,
  input  logic [$clog2(DATA_W/8)-1:0]  addr_off,
  output logic                         mem_req,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [DATA_W-1:0]            mdr_q,
  output logic                         busy,
  output logic                         done,
  output logic                         err_align,
  output logic                         err_tmo,
  output state_e                       state_dbg
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int CNT_W = $clog2(TIMEOUT);

  // Handshake: mem_req stays high for every WAIT cycle; the first cycle in which
  // mem_ack is sampled high while mem_req is high transfers mem_rdata and ends the request.

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         lat_size;
  logic               lat_sign;
  logic [OFF_W-1:0]   lat_off;
  logic [DATA_W-1:0]  ext_data;
  logic [2:0]         off_ext;

  assign off_ext   = 3'(addr_off);
  assign state_dbg = state;

  mdr_extract #(.DATA_W(DATA_W)) u_extract (
    .size      (lat_size),
    .sign_ext  (lat_sign),
    .addr_off  (lat_off),
    .mem_rdata (mem_rdata),
    .ext_data  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_size  <= '0;
      lat_sign  <= 1'b0;
      lat_off   <= '0;
      mdr_q     <= '0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_align <= 1'b0;
      err_tmo   <= 1'b0;
    end else if (LEGACY != 0) begin
      state     <= ST_IDLE;
      mdr_q     <= mem_rdata;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_align <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      done      <= 1'b0;
      err_align <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_req) begin
            err_tmo <= 1'b0;
            if (f_is_legal(size, off_ext, DATA_W)) begin
              lat_size <= size;
              lat_sign <= sign_ext;
              lat_off  <= addr_off;
              cnt      <= '0;
              mem_req  <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_WAIT;
            end else begin
              err_align <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // An ack in the final allowed cycle still completes normally.
          if (mem_ack) begin
            mdr_q   <= ext_data;
            done    <= 1'b1;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_tmo <= 1'b1;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_reg_ctl.sv
// Directed bench for mem_data_reg_ctl: 32-bit instance checked through an
// expected-response queue, plus 64-bit and LEGACY instances checked directly.
module tb_mem_data_reg_ctl;
  import mem_data_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 32-bit DUT ----------------
  logic        load_req = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [1:0]  addr_off = 2'b00;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req, busy, done, err_align, err_tmo;
  logic [31:0] mdr_q;
  state_e      st32;

  mem_data_reg_ctl #(.DATA_W(32), .TIMEOUT(4), .LEGACY(0)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .size(size), .sign_ext(sign_ext),
    .addr_off(addr_off), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mdr_q(mdr_q), .busy(busy), .done(done), .err_align(err_align), .err_tmo(err_tmo),
    .state_dbg(st32)
  );

  // ---------------- 64-bit DUT ----------------
  logic        d_load = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic        d_sext = 1'b0;
  logic [2:0]  d_off = 3'b000;
  logic        d_ack = 1'b0;
  logic [63:0] d_rdata = 64'h0;
  logic        d_req, d_busy, d_done, d_err_align, d_err_tmo;
  logic [63:0] d_mdr;
  state_e      st64;

  mem_data_reg_ctl #(.DATA_W(64), .TIMEOUT(4), .LEGACY(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .load_req(d_load), .size(d_size), .sign_ext(d_sext),
    .addr_off(d_off), .mem_req(d_req), .mem_ack(d_ack), .mem_rdata(d_rdata),
    .mdr_q(d_mdr), .busy(d_busy), .done(d_done), .err_align(d_err_align),
    .err_tmo(d_err_tmo), .state_dbg(st64)
  );

  // ---------------- LEGACY DUT ----------------
  logic [31:0] lg_rdata = 32'h0;
  logic        lg_req, lg_busy, lg_done, lg_err_align, lg_err_tmo;
  logic [31:0] lg_mdr;
  state_e      st_lg;

  mem_data_reg_ctl #(.DATA_W(32), .TIMEOUT(16), .LEGACY(1)) dut_lg (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .size(size), .sign_ext(sign_ext),
    .addr_off(addr_off), .mem_req(lg_req), .mem_ack(mem_ack), .mem_rdata(lg_rdata),
    .mdr_q(lg_mdr), .busy(lg_busy), .done(lg_done), .err_align(lg_err_align),
    .err_tmo(lg_err_tmo), .state_dbg(st_lg)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];   // {done, err_align, mdr_q}
  int busy_cnt = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (mem_req && !prev_req) req_rises++;
    prev_req = mem_req;
    if (rst_n && (done || err_align)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'h0, done, err_align, mdr_q}, 64'h0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("sb_event", {30'h0, done, err_align, mdr_q}, {30'h0, e});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [1:0] sz, input logic s, input logic [1:0] off);
    size = sz; sign_ext = s; addr_off = off; load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Idle k WAIT cycles without ack, then present rdata with ack for one cycle.
  task automatic ack_after(input int k, input logic [31:0] rd);
    repeat (k) tick();
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic load64(input string name, input logic [1:0] sz, input logic s,
                        input logic [2:0] off, input logic [63:0] rd,
                        input logic exp_err, input logic [63:0] exp);
    d_size = sz; d_sext = s; d_off = off; d_load = 1'b1;
    tick();
    d_load = 1'b0;
    if (exp_err) begin
      check({name, "_err"}, {63'h0, d_err_align}, 64'h1);
      check({name, "_noreq"}, {63'h0, d_req}, 64'h0);
    end else begin
      d_ack = 1'b1; d_rdata = rd;
      tick();
      d_ack = 1'b0;
      check({name, "_done"}, {63'h0, d_done}, 64'h1);
    end
    check({name, "_mdr"}, d_mdr, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    check("rst_mdr", {32'h0, mdr_q}, 64'h0);
    check("rst_flags", {59'h0, mem_req, busy, done, err_align, err_tmo}, 64'h0);
    check("rst_state", {63'h0, st32}, {63'h0, ST_IDLE});
    check("rst_lg_mdr", {32'h0, lg_mdr}, 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: signed byte, ack in first WAIT cycle
    exp_q.push_back({2'b10, 32'hFFFF_FF80});
    issue_load(SZ_BYTE, 1'b1, 2'd2);
    check("t1_busy_in_wait", {63'h0, busy}, 64'h1);
    ack_after(0, 32'h1280_FF34);
    check("t1_done_latency", {63'h0, done}, 64'h1);
    tick();

    // 2: unsigned half, ack after 3 WAIT cycles
    busy_cnt = 0;
    exp_q.push_back({2'b10, 32'h0000_8001});
    issue_load(SZ_HALF, 1'b0, 2'd2);
    ack_after(3, 32'h8001_0000);
    tick();
    check("t2_busy_cycles", busy_cnt, 64'd4);

    // 3: misaligned word
    req_rises = 0;
    exp_q.push_back({2'b01, 32'h0000_8001});
    issue_load(SZ_WORD, 1'b0, 2'd1);
    tick(); tick();
    check("t3_no_mem_req", req_rises, 64'd0);

    // 4: timeout, sticky, cleared by next accepted load
    busy_cnt = 0;
    issue_load(SZ_WORD, 1'b0, 2'd0);
    repeat (6) tick();
    check("t4_busy_cycles", busy_cnt, 64'd4);
    check("t4_err_tmo", {63'h0, err_tmo}, 64'h1);
    check("t4_mdr_kept", {32'h0, mdr_q}, 64'h0000_8001);
    repeat (3) tick();
    check("t4_err_tmo_sticky", {63'h0, err_tmo}, 64'h1);
    exp_q.push_back({2'b10, 32'hDEAD_BEEF});
    issue_load(SZ_WORD, 1'b0, 2'd0);
    check("t4_tmo_cleared", {63'h0, err_tmo}, 64'h0);
    ack_after(0, 32'hDEAD_BEEF);
    tick();
    // illegal size on a 32-bit datapath also clears the sticky flag
    issue_load(SZ_WORD, 1'b0, 2'd0);
    repeat (6) tick();
    check("t4_err_tmo_again", {63'h0, err_tmo}, 64'h1);
    exp_q.push_back({2'b01, 32'hDEAD_BEEF});
    issue_load(SZ_DWORD, 1'b0, 2'd0);
    check("t4_illegal_clears_tmo", {63'h0, err_tmo}, 64'h0);
    tick();

    // extra extraction patterns
    exp_q.push_back({2'b10, 32'hFFFF_F00D});
    issue_load(SZ_HALF, 1'b1, 2'd0);
    ack_after(1, 32'h0000_F00D);
    tick();
    exp_q.push_back({2'b10, 32'h0000_00AB});
    issue_load(SZ_BYTE, 1'b0, 2'd3);
    ack_after(0, 32'hAB00_0000);
    tick();

    // 5: ack on the last allowed cycle, second load_req while busy ignored
    exp_q.push_back({2'b10, 32'h8765_4321});
    issue_load(SZ_WORD, 1'b1, 2'd0);
    size = SZ_BYTE; sign_ext = 1'b1; addr_off = 2'd1; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h8765_4321;
    tick();
    mem_ack = 1'b0;
    check("t5_done", {63'h0, done}, 64'h1);
    check("t5_no_tmo", {63'h0, err_tmo}, 64'h0);
    repeat (4) tick();
    check("t5_one_done_only", {63'h0, busy}, 64'h0);

    // 6: reset mid-WAIT, late ack ignored
    issue_load(SZ_BYTE, 1'b0, 2'd0);
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_state", {63'h0, st32}, {63'h0, ST_IDLE});
    check("t6_mdr", {32'h0, mdr_q}, 64'h0);
    check("t6_flags", {59'h0, mem_req, busy, done, err_align, err_tmo}, 64'h0);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    tick();
    check("t6_late_ack", {32'h0, mdr_q}, 64'h0);
    check("t6_late_busy", {63'h0, busy}, 64'h0);

    // 64-bit instance
    load64("d64_dword", SZ_DWORD, 1'b0, 3'd0, 64'h0123_4567_89AB_CDEF, 1'b0,
           64'h0123_4567_89AB_CDEF);
    load64("d64_sword", SZ_WORD, 1'b1, 3'd4, 64'h8000_0001_0000_0000, 1'b0,
           64'hFFFF_FFFF_8000_0001);
    load64("d64_sbyte", SZ_BYTE, 1'b1, 3'd7, 64'h80FF_FFFF_FFFF_FFFF, 1'b0,
           64'hFFFF_FFFF_FFFF_FF80);
    load64("d64_misal", SZ_DWORD, 1'b0, 3'd4, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);

    // LEGACY instance: mdr_q follows rdata one cycle later, handshake inert
    lg_rdata = 32'hA5A5_0001;
    tick();
    check("lg_follow0", {32'h0, lg_mdr}, 64'hA5A5_0001);
    lg_rdata = 32'h5A5A_0002;
    check("lg_hold", {32'h0, lg_mdr}, 64'hA5A5_0001);
    tick();
    check("lg_follow1", {32'h0, lg_mdr}, 64'h5A5A_0002);
    load_req = 1'b1; size = SZ_WORD; addr_off = 2'd0;
    tick();
    load_req = 1'b0;
    check("lg_outputs_idle", {59'h0, lg_req, lg_busy, lg_done, lg_err_align, lg_err_tmo},
          64'h0);
    exp_q.push_back({2'b10, 32'h1111_2222});
    ack_after(0, 32'h1111_2222);
    tick();

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
